// File: rtl/cory_dist_mask_pkg.sv
// Shared definitions for the cory_dist_mask distributor.
// Holds the lane-slice macro, the clog2 helper used for counter and pointer widths,
// and the depth value that selects lockstep mode.
`ifndef CORY_DIST_MASK_PKG_SV
`define CORY_DIST_MASK_PKG_SV

// Lane j of a packed N*W bus: use as bus[`CORY_LANE_SLICE(j, W)]
`define CORY_LANE_SLICE(j, w) ((j)*(w)) +: (w)

package cory_dist_mask_pkg;

   // Depth value that selects the unbuffered lockstep datapath
   localparam int CORY_DIST_LOCKSTEP = 0;

   // ceil(log2(v)); clog2(1) = 0. The bound stops before 1<<31 turns negative.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

`endif

// File: rtl/cory_dist_mask_if.sv
// Handshake bundle between a producer, the distributor and N lane consumers.
// Signals: i_a_v/i_a_d/i_a_m/o_a_r (input side), o_zx_v/o_zx_d/i_zx_r (lanes),
// and o_busy (status). master = producer/consumer side, slave = distributor.
interface cory_dist_mask_if #(
   parameter int N = 8,
   parameter int W = 8
);
   logic           i_a_v;
   logic [W-1:0]   i_a_d;
   logic [N-1:0]   i_a_m;
   logic           o_a_r;
   logic [N-1:0]   o_zx_v;
   logic [N*W-1:0] o_zx_d;
   logic [N-1:0]   i_zx_r;
   logic           o_busy;

   modport master (
      output i_a_v, i_a_d, i_a_m, i_zx_r,
      input  o_a_r, o_zx_v, o_zx_d, o_busy
   );

   modport slave (
      input  i_a_v, i_a_d, i_a_m, i_zx_r,
      output o_a_r, o_zx_v, o_zx_d, o_busy
   );
endinterface

// File: rtl/cory_dist_lane.sv
// One lane buffer: D-entry FIFO with occupancy count, full/empty flags and head data.
// Latency: a pushed item is visible at head the cycle after the push.
// Backpressure: the caller must not push while full nor pop while empty.
// Ports: push/push_d write side, pop read side, full/empty/head status.
module cory_dist_lane
   import cory_dist_mask_pkg::*;
#(
   parameter int W = 8,
   parameter int D = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic [W-1:0] push_d,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);
   localparam int CW = clog2(D + 1);
   localparam int PW = (D > 1) ? clog2(D) : 1;

   logic [W-1:0]  mem [D];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] cnt;

   // Pointers wrap at D explicitly so non-power-of-two depths work
   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(D - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full  = (cnt == CW'(D));
   assign empty = (cnt == '0);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) wr_ptr <= bump(wr_ptr);
         if (pop)  rd_ptr <= bump(rd_ptr);
         // Simultaneous push and pop leaves the count unchanged
         if (push && !pop)      cnt <= cnt + CW'(1);
         else if (pop && !push) cnt <= cnt - CW'(1);
      end
   end

   // Storage needs no reset: entries are only observed when cnt says valid
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_d;
   end

`ifdef CORY_MON
   a_no_overflow:  assert property (@(posedge clk) disable iff (!reset_n) !(push && full));
   a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n) !(pop && empty));
`endif
endmodule

// File: rtl/cory_dist_mask.sv
// Distributes one input transaction (data + lane mask) to any subset of N lanes.
// Latency: D=0 combinational pass-through; D>=1 one cycle through a per-lane FIFO.
// Backpressure: D=0 holds the input until every selected lane accepted; D>=1 stalls
// only while a selected lane buffer is full.
// Ports: clk, reset_n (async, active-low), bus (slave modport of cory_dist_mask_if).
module cory_dist_mask
   import cory_dist_mask_pkg::*;
#(
   parameter int N = 8,
   parameter int W = 8,
   parameter int D = 0
) (
   input logic              clk,
   input logic              reset_n,
   cory_dist_mask_if.slave  bus
);

   if (D == CORY_DIST_LOCKSTEP) begin : g_lockstep
      // hold[j]: lane j already took the current transaction
      logic [N-1:0] hold;
      logic [N-1:0] done;

      // reset_n gates valid so lanes go quiet the instant reset asserts
      assign bus.o_zx_v = {N{bus.i_a_v & reset_n}} & bus.i_a_m & ~hold;
      assign done       = (bus.o_zx_v & bus.i_zx_r) | hold;
      assign bus.o_a_r  = &(done | ~bus.i_a_m);
      assign bus.o_busy = |hold;

      for (genvar j = 0; j < N; j++) begin : g_dat
         assign bus.o_zx_d[`CORY_LANE_SLICE(j, W)] = bus.i_a_d;
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)                    hold <= '0;
         else if (bus.i_a_v && bus.o_a_r) hold <= '0;
         else                             hold <= done;
      end
   end else begin : g_buffered
      logic [N-1:0] full;
      logic [N-1:0] empty;
      logic         xfer;

      // Full is the pre-pop state: a lane draining this cycle still refuses input
      assign bus.o_a_r  = &(~bus.i_a_m | ~full);
      assign xfer       = bus.i_a_v & bus.o_a_r;
      assign bus.o_zx_v = ~empty;
      assign bus.o_busy = |(~empty);

      for (genvar j = 0; j < N; j++) begin : g_lane
         cory_dist_lane #(
            .W (W),
            .D (D)
         ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (xfer & bus.i_a_m[j]),
            .push_d  (bus.i_a_d),
            .pop     (bus.o_zx_v[j] & bus.i_zx_r[j]),
            .full    (full[j]),
            .empty   (empty[j]),
            .head    (bus.o_zx_d[`CORY_LANE_SLICE(j, W)])
         );
      end
   end

`ifdef CORY_MON
   for (genvar j = 0; j < N; j++) begin : g_mon
      cory_monitor #(.W(W)) u_mon (
         .clk     (clk),
         .reset_n (reset_n),
         .v       (bus.o_zx_v[j]),
         .r       (bus.i_zx_r[j]),
         .d       (bus.o_zx_d[`CORY_LANE_SLICE(j, W)])
      );
   end

   a_in_stable: assert property (@(posedge clk) disable iff (!reset_n)
      (bus.i_a_v && !bus.o_a_r) |=> ($stable(bus.i_a_d) && $stable(bus.i_a_m)));
`endif
endmodule
